cp0_reg: RTL and testbench

- Coprocessor-0 register file for MiniMIPS32; the responder end of the CP0 read/write interface driven by the execute stage (cp0_re/raddr on the read side; cp0_we/waddr/wdata on the write side).
- Holds BadVAddr, Count, Compare, Status, Cause and EPC.
- Accepts committed exceptions and ERET from the memory stage.
- Generates the interrupt request, pipeline flush and redirect target.

---
 rtl/cp0_reg_pkg.sv | 63 ++++++
 rtl/cp0_reg_if.sv | 29 ++
 rtl/cp0_timer.sv | 58 +++++
 rtl/cp0_reg.sv | 188 ++++++++++++++++++
 tb/tb_cp0_reg.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_reg_pkg.sv
// -----------------------------------------------------------------------------
// cp0_reg_pkg
// Shared definitions for the MiniMIPS32 coprocessor-0 register file:
//   - CP0 register numbers (BadVAddr, Count, Compare, Status, Cause, EPC)
//   - exception codes carried on the exception-code bus
//   - Status/Cause field positions and the Status software-write mask
//   - commit classification helper used by the register file
// -----------------------------------------------------------------------------
package cp0_reg_pkg;

    // Width of the exception-code bus between the pipeline and CP0.
    localparam int EXC_CODE_BUS = 5;

    typedef logic [EXC_CODE_BUS-1:0] exc_code_t;
    typedef logic [4:0]              reg_num_t;

    // CP0 register numbers.
    localparam reg_num_t CP0_BADVADDR = 5'd8;
    localparam reg_num_t CP0_COUNT    = 5'd9;
    localparam reg_num_t CP0_COMPARE  = 5'd11;
    localparam reg_num_t CP0_STATUS   = 5'd12;
    localparam reg_num_t CP0_CAUSE    = 5'd13;
    localparam reg_num_t CP0_EPC      = 5'd14;

    // Exception codes. EXC_NONE and EXC_ERET are pipeline-internal codes,
    // never written into Cause.ExcCode.
    localparam exc_code_t EXC_INT  = 5'h00;
    localparam exc_code_t EXC_ADEL = 5'h04;
    localparam exc_code_t EXC_ADES = 5'h05;
    localparam exc_code_t EXC_SYS  = 5'h08;
    localparam exc_code_t EXC_OV   = 5'h0c;
    localparam exc_code_t EXC_NONE = 5'h10;
    localparam exc_code_t EXC_ERET = 5'h11;

    // Status fields.
    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    // Bits software may change with MTC0: IM[15:8], EXL, IE.
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    // What the memory stage is committing this cycle.
    typedef enum logic [1:0] {
        CMT_NONE = 2'd0,
        CMT_EXC  = 2'd1,
        CMT_ERET = 2'd2
    } commit_e;

    function automatic commit_e decode_commit(input exc_code_t code);
        if (code == EXC_NONE) begin
            return CMT_NONE;
        end else if (code == EXC_ERET) begin
            return CMT_ERET;
        end else begin
            return CMT_EXC;
        end
    endfunction

    // Address-error exceptions are the only ones that capture BadVAddr.
    function automatic logic is_addr_exc(input exc_code_t code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_reg_if.sv
// -----------------------------------------------------------------------------
// cp0_reg_if
// CP0 read/write port between the execute stage (master) and the CP0
// register file (slave).
//   re     read enable             raddr  read register number
//   rdata  read data (combinational from the register file)
//   we     write enable (MTC0)     waddr  write register number
//   wdata  write data
// -----------------------------------------------------------------------------
interface cp0_reg_if
    import cp0_reg_pkg::*;
    ;
    logic        re;
    reg_num_t    raddr;
    logic [31:0] rdata;
    logic        we;
    reg_num_t    waddr;
    logic [31:0] wdata;

    modport master (
        output re, raddr, we, waddr, wdata,
        input  rdata
    );

    modport slave (
        input  re, raddr, we, waddr, wdata,
        output rdata
    );
endinterface

// File: rtl/cp0_timer.sv
// -----------------------------------------------------------------------------
// cp0_timer
// Count/Compare timer for the CP0 register file. Only built when the
// CP0_TIMER_EN macro is defined; without it this file contributes nothing.
//   clk         clock               srst        synchronous active-high reset
//   count_we    load Count          compare_we  load Compare (clears timer_int)
//   wdata       write data
//   count       Count register      compare     Compare register
//   timer_int   sticky timer interrupt flag
// -----------------------------------------------------------------------------
`ifdef CP0_TIMER_EN
module cp0_timer (
    input  logic        clk,
    input  logic        srst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);

    logic [31:0] count_reg,     count_next;
    logic [31:0] compare_reg,   compare_next;
    logic        timer_int_reg, timer_int_next;

    always_comb begin
        // A software load replaces the increment for that cycle; the +1
        // wraps naturally from 32'hFFFF_FFFF to 0.
        count_next     = count_we ? wdata : count_reg + 32'd1;
        compare_next   = compare_we ? wdata : compare_reg;
        timer_int_next = timer_int_reg;
        // The clear from a Compare write wins over a match in the same cycle.
        if (compare_we) begin
            timer_int_next = 1'b0;
        end else if ((count_reg == compare_reg) && (compare_reg != 32'd0)) begin
            timer_int_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg     <= 32'd0;
            compare_reg   <= 32'd0;
            timer_int_reg <= 1'b0;
        end else begin
            count_reg     <= count_next;
            compare_reg   <= compare_next;
            timer_int_reg <= timer_int_next;
        end
    end

    assign count     = count_reg;
    assign compare   = compare_reg;
    assign timer_int = timer_int_reg;

endmodule
`endif

// File: rtl/cp0_reg.sv
// -----------------------------------------------------------------------------
// cp0_reg
// MiniMIPS32 coprocessor-0 register file: BadVAddr, Count, Compare, Status,
// Cause and EPC. Takes committed exceptions / ERET from the memory stage,
// produces the interrupt request and a one-cycle flush with redirect target.
//
// Optional feature: define CP0_TIMER_EN to build the Count/Compare timer
// (cp0_timer). Without it Count/Compare read 0 and timer_int_o is 0.
//
// Ports:
//   cpu_clk_50M     clock, all state on the rising edge
//   cpu_rst         synchronous active-high reset
//   bus             CP0 read/write port (slave side of cp0_reg_if)
//   int_i           hardware interrupt lines (level)
//   exc_code_i      committed exception code, EXC_NONE when idle
//   exc_pc_i        PC of the excepting instruction
//   exc_in_delay_i  excepting instruction sits in a delay slot
//   exc_badvaddr_i  faulting address for address errors
//   int_req_o       enabled interrupt pending
//   flush_o         one-cycle flush pulse, cycle after a commit
//   exc_target_o    redirect PC, valid while flush_o=1
//   status_o / cause_o / epc_o   register contents
//   timer_int_o     timer interrupt flag
// -----------------------------------------------------------------------------
module cp0_reg
    import cp0_reg_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0100,
    parameter logic [31:0] STATUS_RESET = 32'h1000_0000
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    cp0_reg_if.slave    bus,
    input  logic [4:0]  int_i,
    input  exc_code_t   exc_code_i,
    input  logic [31:0] exc_pc_i,
    input  logic        exc_in_delay_i,
    input  logic [31:0] exc_badvaddr_i,
    output logic        int_req_o,
    output logic        flush_o,
    output logic [31:0] exc_target_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        timer_int_o
);

    commit_e     commit;
    logic        sw_we;

    logic [31:0] status_reg,   status_next;
    logic [31:0] epc_reg,      epc_next;
    logic [31:0] badvaddr_reg, badvaddr_next;
    logic        bd_reg,       bd_next;
    exc_code_t   exc_code_reg, exc_code_next;
    logic [1:0]  ip_sw_reg,    ip_sw_next;
    logic [4:0]  ip_hw_reg;
    logic        flush_reg,    flush_next;
    logic [31:0] target_reg,   target_next;

    logic        timer_int;
    logic [31:0] cause;
    logic [31:0] rdata;

    assign commit = decode_commit(exc_code_i);
    // A commit in the same cycle drops the software write completely,
    // including any write aimed at the timer registers.
    assign sw_we  = bus.we && (commit == CMT_NONE);

`ifdef CP0_TIMER_EN
    logic [31:0] count;
    logic [31:0] compare;

    cp0_timer u_timer (
        .clk        (cpu_clk_50M),
        .srst       (cpu_rst),
        .count_we   (sw_we && (bus.waddr == CP0_COUNT)),
        .compare_we (sw_we && (bus.waddr == CP0_COMPARE)),
        .wdata      (bus.wdata),
        .count      (count),
        .compare    (compare),
        .timer_int  (timer_int)
    );
`else
    assign timer_int = 1'b0;
`endif

    // Cause: BD[31], IP[15:8] = {timer, int_i[4:0], sw[1:0]}, ExcCode[6:2].
    assign cause = {bd_reg, 15'd0, timer_int, ip_hw_reg, ip_sw_reg,
                    1'b0, exc_code_reg, 2'b00};

    always_comb begin
        status_next   = status_reg;
        epc_next      = epc_reg;
        badvaddr_next = badvaddr_reg;
        bd_next       = bd_reg;
        exc_code_next = exc_code_reg;
        ip_sw_next    = ip_sw_reg;
        flush_next    = 1'b0;
        target_next   = 32'd0;
        case (commit)
            CMT_EXC: begin
                // A nested exception (EXL already set) keeps the original
                // return point and delay-slot flag.
                if (!status_reg[STATUS_EXL]) begin
                    epc_next = exc_in_delay_i ? (exc_pc_i - 32'd4) : exc_pc_i;
                    bd_next  = exc_in_delay_i;
                end
                exc_code_next           = exc_code_i;
                status_next[STATUS_EXL] = 1'b1;
                if (is_addr_exc(exc_code_i)) begin
                    badvaddr_next = exc_badvaddr_i;
                end
                flush_next  = 1'b1;
                target_next = EXC_VECTOR;
            end
            CMT_ERET: begin
                status_next[STATUS_EXL] = 1'b0;
                flush_next              = 1'b1;
                target_next             = epc_reg;
            end
            default: begin
                if (sw_we) begin
                    case (bus.waddr)
                        CP0_STATUS: status_next = (status_reg & ~STATUS_WMASK)
                                                | (bus.wdata & STATUS_WMASK);
                        CP0_CAUSE:  ip_sw_next  = bus.wdata[9:8];
                        CP0_EPC:    epc_next    = bus.wdata;
                        default:    ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            status_reg   <= STATUS_RESET;
            epc_reg      <= 32'd0;
            badvaddr_reg <= 32'd0;
            bd_reg       <= 1'b0;
            exc_code_reg <= '0;
            ip_sw_reg    <= 2'b00;
            ip_hw_reg    <= 5'd0;
            flush_reg    <= 1'b0;
            target_reg   <= 32'd0;
        end else begin
            status_reg   <= status_next;
            epc_reg      <= epc_next;
            badvaddr_reg <= badvaddr_next;
            bd_reg       <= bd_next;
            exc_code_reg <= exc_code_next;
            ip_sw_reg    <= ip_sw_next;
            ip_hw_reg    <= int_i;
            flush_reg    <= flush_next;
            target_reg   <= target_next;
        end
    end

    // Combinational read; the execute stage forwards in-flight writes itself.
    always_comb begin
        rdata = 32'd0;
        if (bus.re) begin
            case (bus.raddr)
                CP0_BADVADDR: rdata = badvaddr_reg;
`ifdef CP0_TIMER_EN
                CP0_COUNT:    rdata = count;
                CP0_COMPARE:  rdata = compare;
`endif
                CP0_STATUS:   rdata = status_reg;
                CP0_CAUSE:    rdata = cause;
                CP0_EPC:      rdata = epc_reg;
                default:      rdata = 32'd0;
            endcase
        end
    end

    assign bus.rdata    = rdata;
    assign int_req_o    = status_reg[STATUS_IE] & ~status_reg[STATUS_EXL]
                        & (|(cause[15:8] & status_reg[15:8]));
    assign flush_o      = flush_reg;
    assign exc_target_o = target_reg;
    assign status_o     = status_reg;
    assign cause_o      = cause;
    assign epc_o        = epc_reg;
    assign timer_int_o  = timer_int;

endmodule

// File: tb/tb_cp0_reg.sv
// -----------------------------------------------------------------------------
// tb_cp0_reg
// Directed bench for cp0_reg. The driver pushes hand-computed expectations
// into queues; a monitor on the falling edge pops them when the DUT presents
// an output: a read (re=1), a flush pulse, or a probe of a status signal.
// Handles both builds (CP0_TIMER_EN defined or not).
// -----------------------------------------------------------------------------
module tb_cp0_reg;
    import cp0_reg_pkg::*;

    typedef enum int {P_INT_REQ, P_TIMER, P_FLUSH, P_TARGET,
                      P_STATUS, P_CAUSE, P_EPC} probe_e;

    typedef struct {
        string       name;
        logic [31:0] val;
        probe_e      kind;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [4:0]  int_i;
    exc_code_t   exc_code;
    logic [31:0] exc_pc;
    logic        exc_in_delay;
    logic [31:0] exc_badvaddr;
    logic        int_req;
    logic        flush;
    logic [31:0] exc_target;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        timer_int;
    logic        probe_en;

    int checks = 0;
    int errors = 0;

    exp_t rd_q[$];
    exp_t fl_q[$];
    exp_t pr_q[$];

    cp0_reg_if bus ();

    cp0_reg dut (
        .cpu_clk_50M    (clk),
        .cpu_rst        (rst),
        .bus            (bus),
        .int_i          (int_i),
        .exc_code_i     (exc_code),
        .exc_pc_i       (exc_pc),
        .exc_in_delay_i (exc_in_delay),
        .exc_badvaddr_i (exc_badvaddr),
        .int_req_o      (int_req),
        .flush_o        (flush),
        .exc_target_o   (exc_target),
        .status_o       (status),
        .cause_o        (cause),
        .epc_o          (epc),
        .timer_int_o    (timer_int)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    // ---------------- monitor ----------------
    task automatic compare(input exp_t e, input logic [31:0] got);
        checks++;
        if (got !== e.val) begin
            errors++;
            $display("FAIL %s got %08h expected %08h", e.name, got, e.val);
        end else begin
            $display("ok   %s = %08h", e.name, got);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [31:0] got;
        if (bus.re) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_unexpected got %08h expected no read", bus.rdata);
            end else begin
                e = rd_q.pop_front();
                compare(e, bus.rdata);
            end
        end
        if (flush) begin
            if (fl_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL flush_unexpected got 1 expected 0 (target %08h)", exc_target);
            end else begin
                e = fl_q.pop_front();
                compare(e, exc_target);
            end
        end
        if (probe_en) begin
            if (pr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL probe_underflow got empty expected entry");
            end else begin
                e = pr_q.pop_front();
                case (e.kind)
                    P_INT_REQ: got = {31'd0, int_req};
                    P_TIMER:   got = {31'd0, timer_int};
                    P_FLUSH:   got = {31'd0, flush};
                    P_TARGET:  got = exc_target;
                    P_STATUS:  got = status;
                    P_CAUSE:   got = cause;
                    default:   got = epc;
                endcase
                compare(e, got);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input reg_num_t a, input logic [31:0] v, input string n);
        exp_t e;
        e.name = n; e.val = v; e.kind = P_INT_REQ;
        rd_q.push_back(e);
        bus.re = 1'b1; bus.raddr = a;
        tick();
        bus.re = 1'b0;
    endtask

    task automatic wr(input reg_num_t a, input logic [31:0] d);
        bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
        tick();
        bus.we = 1'b0;
    endtask

    task automatic probe(input probe_e k, input logic [31:0] v, input string n);
        exp_t e;
        e.name = n; e.val = v; e.kind = k;
        pr_q.push_back(e);
        probe_en = 1'b1;
        tick();
        probe_en = 1'b0;
    endtask

    // Commit an exception/ERET for one cycle; tgt is the expected redirect.
    task automatic commit(input exc_code_t c, input logic [31:0] pc, input logic dly,
                          input logic [31:0] bad, input logic [31:0] tgt, input string n);
        exp_t e;
        e.name = n; e.val = tgt; e.kind = P_TARGET;
        fl_q.push_back(e);
        exc_code = c; exc_pc = pc; exc_in_delay = dly; exc_badvaddr = bad;
        tick();
        exc_code = EXC_NONE;
    endtask

    initial begin
        bit hit;
        rst = 1'b1; probe_en = 1'b0; int_i = 5'd0;
        exc_code = EXC_NONE; exc_pc = 32'd0; exc_in_delay = 1'b0; exc_badvaddr = 32'd0;
        bus.re = 1'b0; bus.raddr = 5'd0; bus.we = 1'b0; bus.waddr = 5'd0; bus.wdata = 32'd0;
        tick(); tick();
        probe(P_STATUS, 32'h1000_0000, "rst_status_o");
        probe(P_FLUSH,  32'd0,         "rst_flush");
        probe(P_TARGET, 32'd0,         "rst_target");
        probe(P_TIMER,  32'd0,         "rst_timer_int");
        rst = 1'b0;

        // Reset values through the read port, plus unmapped numbers.
        rd(CP0_STATUS,   32'h1000_0000, "rd_status_rst");
        rd(CP0_CAUSE,    32'd0,         "rd_cause_rst");
        rd(CP0_EPC,      32'd0,         "rd_epc_rst");
        rd(CP0_BADVADDR, 32'd0,         "rd_badvaddr_rst");
        wr(5'd3, 32'hFFFF_FFFF);
        rd(5'd3,  32'd0, "rd_unmapped3");
        rd(5'd31, 32'd0, "rd_unmapped31");
        probe(P_INT_REQ, 32'd0, "int_req_rst");

        // Interrupt path: enable IE and all IM, raise int_i[0].
        int_i = 5'b00001;
        wr(CP0_STATUS, 32'h0000_FF01);
        probe(P_INT_REQ, 32'd1, "int_req_hw0");
        rd(CP0_CAUSE,  32'h0000_0400, "rd_cause_ip2");
        rd(CP0_STATUS, 32'h1000_FF01, "rd_status_wr");
        wr(CP0_CAUSE, 32'hFFFF_FFFF);
        rd(CP0_CAUSE, 32'h0000_0700, "rd_cause_swmask");
        wr(CP0_CAUSE, 32'd0);
        wr(CP0_STATUS, 32'h0000_0001);
        probe(P_INT_REQ, 32'd0, "int_req_im_off");
        wr(CP0_STATUS, 32'hFFFF_FFFF);
        probe(P_STATUS,  32'h1000_FF03, "status_wmask");
        probe(P_INT_REQ, 32'd0,         "int_req_exl");
        wr(CP0_STATUS, 32'h0000_FF01);

        // Overflow in a delay slot.
        commit(EXC_OV, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 32'h0000_0100, "flush_ov");
        rd(CP0_EPC,      32'h8000_000C, "rd_epc_ov");
        rd(CP0_CAUSE,    32'h8000_0430, "rd_cause_ov");
        rd(CP0_STATUS,   32'h1000_FF03, "rd_status_ov");
        rd(CP0_BADVADDR, 32'd0,         "rd_badvaddr_ov");
        probe(P_EPC,   32'h8000_000C, "epc_o_ov");
        probe(P_CAUSE, 32'h8000_0430, "cause_o_ov");

        // Nested syscall with EXL set, then ERET back to the original EPC.
        commit(EXC_SYS, 32'h0000_0100, 1'b0, 32'd0, 32'h0000_0100, "flush_sys_nested");
        rd(CP0_EPC,   32'h8000_000C, "rd_epc_nested");
        rd(CP0_CAUSE, 32'h8000_0420, "rd_cause_nested");
        commit(EXC_ERET, 32'd0, 1'b0, 32'd0, 32'h8000_000C, "flush_eret1");
        rd(CP0_STATUS, 32'h1000_FF01, "rd_status_eret1");
        probe(P_INT_REQ, 32'd1, "int_req_after_eret");

        // Back-to-back: ADEL then ERET on consecutive cycles.
        commit(EXC_ADEL, 32'h0000_0200, 1'b0, 32'h1234_5679, 32'h0000_0100, "flush_adel");
        commit(EXC_ERET, 32'd0, 1'b0, 32'd0, 32'h0000_0200, "flush_eret_b2b");
        rd(CP0_BADVADDR, 32'h1234_5679, "rd_badvaddr_adel");
        rd(CP0_EPC,      32'h0000_0200, "rd_epc_adel");
        rd(CP0_CAUSE,    32'h0000_0410, "rd_cause_adel");
        rd(CP0_STATUS,   32'h1000_FF01, "rd_status_b2b");

        // pc-4 wrap in a delay slot at PC 0.
        commit(EXC_ADES, 32'd0, 1'b1, 32'hCAFE_0000, 32'h0000_0100, "flush_ades");
        rd(CP0_EPC,      32'hFFFF_FFFC, "rd_epc_wrap");
        rd(CP0_BADVADDR, 32'hCAFE_0000, "rd_badvaddr_ades");
        rd(CP0_CAUSE,    32'h8000_0414, "rd_cause_ades");
        commit(EXC_ERET, 32'd0, 1'b0, 32'd0, 32'hFFFF_FFFC, "flush_eret_wrap");
        wr(CP0_BADVADDR, 32'h1111_1111);
        rd(CP0_BADVADDR, 32'hCAFE_0000, "rd_badvaddr_ro");

        // Same-cycle software write is dropped for an exception and for ERET.
        bus.we = 1'b1; bus.waddr = CP0_EPC; bus.wdata = 32'h5555_5555;
        commit(EXC_SYS, 32'h0000_0300, 1'b0, 32'd0, 32'h0000_0100, "flush_sys_wr");
        bus.we = 1'b0;
        rd(CP0_EPC, 32'h0000_0300, "rd_epc_wr_dropped");
        bus.we = 1'b1; bus.waddr = CP0_STATUS; bus.wdata = 32'd0;
        commit(EXC_ERET, 32'd0, 1'b0, 32'd0, 32'h0000_0300, "flush_eret_wr");
        bus.we = 1'b0;
        rd(CP0_STATUS, 32'h1000_FF01, "rd_status_wr_dropped");
        wr(CP0_EPC, 32'hABCD_0000);
        probe(P_EPC, 32'hABCD_0000, "epc_o_sw");

`ifdef CP0_TIMER_EN
        wr(CP0_COUNT, 32'hFFFF_FFFF);
        rd(CP0_COUNT, 32'hFFFF_FFFF, "rd_count_load");
        rd(CP0_COUNT, 32'd0,         "rd_count_wrap");
        wr(CP0_COMPARE, 32'd5);
        wr(CP0_COUNT, 32'd0);
        hit = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (timer_int) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) begin
            checks++; errors++;
            $display("FAIL timer_rise_timeout got 0 expected 1 within 20 cycles");
        end
        rd(CP0_COUNT, 32'd6, "rd_count_at_rise");
        probe(P_TIMER, 32'd1, "timer_sticky");
        rd(CP0_CAUSE, 32'h0000_8420, "rd_cause_timer");
        wr(CP0_COMPARE, 32'd7);
        probe(P_TIMER, 32'd0, "timer_cleared");
        rd(CP0_COMPARE, 32'd7, "rd_compare");
`else
        hit = 1'b0;
        wr(CP0_COUNT, 32'd123);
        rd(CP0_COUNT, 32'd0, "rd_count_absent");
        wr(CP0_COMPARE, 32'd5);
        rd(CP0_COMPARE, 32'd0, "rd_compare_absent");
        probe(P_TIMER, 32'd0, "timer_tied0");
        rd(CP0_CAUSE, 32'h0000_0420, "rd_cause_no_timer");
`endif

        // Reset arriving together with a commit wins.
        int_i = 5'd0;
        rst = 1'b1;
        exc_code = EXC_SYS; exc_pc = 32'h0000_0400;
        tick();
        exc_code = EXC_NONE;
        rst = 1'b0;
        probe(P_FLUSH,  32'd0, "rst_mid_flush");
        probe(P_TARGET, 32'd0, "rst_mid_target");
        rd(CP0_STATUS,   32'h1000_0000, "rd_status_rst_mid");
        rd(CP0_EPC,      32'd0,         "rd_epc_rst_mid");
        rd(CP0_CAUSE,    32'd0,         "rd_cause_rst_mid");
        rd(CP0_BADVADDR, 32'd0,         "rd_badvaddr_rst_mid");

        tick(); tick();
        checks++;
        if (rd_q.size() != 0) begin
            errors++;
            $display("FAIL rd_queue_left got %0d expected 0", rd_q.size());
        end
        checks++;
        if (fl_q.size() != 0) begin
            errors++;
            $display("FAIL flush_missing got %0d pending expected 0", fl_q.size());
        end
        checks++;
        if (pr_q.size() != 0) begin
            errors++;
            $display("FAIL probe_queue_left got %0d expected 0", pr_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
